// File: rtl/frame_serializer_if.sv
// Frame producer / UART transmit FIFO signals for frame_serializer.
// The serializer uses the slave modport; the producer/FIFO side uses master.
interface frame_serializer_if;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic [15:0] frames_sent;

  modport master (
    output frame_data, frame_valid, tx_full,
    input  frame_ready, wr_uart, w_data, busy, frames_sent
  );

  modport slave (
    input  frame_data, frame_valid, tx_full,
    output frame_ready, wr_uart, w_data, busy, frames_sent
  );
endinterface

// File: rtl/frame_serializer.sv
// Serializes a 32-bit word into a six-byte UART frame:
// sync byte, four data bytes (MSB first) and an XOR checksum, then a fixed idle gap.
module frame_serializer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned GAP_CYCLES = 16
) (
  input logic               pclk,
  input logic               rst,
  frame_serializer_if.slave bus
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    StIdle, StSync, StD0, StD1, StD2, StD3, StChk, StGap
  } state_e;

  state_e          state_q;
  logic [31:0]     word_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            wr_uart_q;
  logic [7:0]      w_data_q;
  logic [15:0]     frames_sent_q;

  logic [7:0] tx_byte;
  state_e     tx_next;

  // Byte to emit and the state that follows once it is written.
  always_comb begin
    tx_byte = SYNC_BYTE;
    tx_next = StIdle;
    unique case (state_q)
      StSync: begin tx_byte = SYNC_BYTE;     tx_next = StD0;  end
      StD0:   begin tx_byte = word_q[31:24]; tx_next = StD1;  end
      StD1:   begin tx_byte = word_q[23:16]; tx_next = StD2;  end
      StD2:   begin tx_byte = word_q[15:8];  tx_next = StD3;  end
      StD3:   begin tx_byte = word_q[7:0];   tx_next = StChk; end
      StChk: begin
        tx_byte = word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
        tx_next = (GAP_CYCLES == 0) ? StIdle : StGap;
      end
      default: begin tx_byte = SYNC_BYTE; tx_next = StIdle; end
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      word_q        <= '0;
      gap_cnt_q     <= '0;
      wr_uart_q     <= 1'b0;
      w_data_q      <= 8'h00;
      frames_sent_q <= 16'h0000;
    end else begin
      wr_uart_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.frame_valid) begin
            word_q  <= bus.frame_data;
            state_q <= StSync;
          end
        end
        StGap: begin
          if (32'(gap_cnt_q) + 32'd1 >= 32'(GAP_CYCLES)) begin
            gap_cnt_q <= '0;
            state_q   <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: begin
          // Back-pressure simply holds the state, so no byte is skipped or repeated.
          if (!bus.tx_full) begin
            wr_uart_q <= 1'b1;
            w_data_q  <= tx_byte;
            state_q   <= tx_next;
            gap_cnt_q <= '0;
            if (state_q == StChk) begin
              frames_sent_q <= frames_sent_q + 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.frame_ready = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.wr_uart     = wr_uart_q;
  assign bus.w_data      = w_data_q;
  assign bus.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer: directed scenarios plus random traffic
// compared every cycle against a byte-queue reference model.
module tb_frame_serializer;

  localparam int unsigned Gap = 16;

  logic pclk = 1'b0;
  logic rst  = 1'b0;

  always #5 pclk = ~pclk;

  frame_serializer_if bus ();
  frame_serializer_if bus0 ();

  frame_serializer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(Gap)) u_dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  frame_serializer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) u_dut0 (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus0)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes still owed for the current frame, plus remaining gap cycles.
  logic [7:0]  m_q[$];
  int          m_gap;
  logic        m_wr;
  logic [7:0]  m_wd;
  logic [15:0] m_sent;

  logic [7:0] cap[$];
  logic [7:0] cap0[$];
  int         cyc = 0;
  int         last_strobe = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_gap  = 0;
    m_wr   = 1'b0;
    m_wd   = 8'h00;
    m_sent = 16'h0000;
  endfunction

  task automatic model_edge();
    logic [31:0] d;
    m_wr = 1'b0;
    if (m_q.size() > 0) begin
      if (!bus.tx_full) begin
        m_wr = 1'b1;
        m_wd = m_q.pop_front();
        if (m_q.size() == 0) begin
          m_sent = m_sent + 16'd1;
          m_gap  = Gap;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (bus.frame_valid) begin
      d = bus.frame_data;
      m_q.push_back(8'hA5);
      m_q.push_back(d[31:24]);
      m_q.push_back(d[23:16]);
      m_q.push_back(d[15:8]);
      m_q.push_back(d[7:0]);
      m_q.push_back(d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
    end
  endtask

  task automatic step();
    logic idle;
    model_edge();
    @(posedge pclk);
    #1;
    cyc++;
    idle = (m_q.size() == 0) && (m_gap == 0);
    check_eq("frame_ready", bus.frame_ready, idle);
    check_eq("busy", bus.busy, !idle);
    check_eq("wr_uart", bus.wr_uart, m_wr);
    check_eq("w_data", bus.w_data, m_wd);
    check_eq("frames_sent", bus.frames_sent, m_sent);
    if (bus.wr_uart) begin
      cap.push_back(bus.w_data);
      last_strobe = cyc;
    end
    if (bus0.wr_uart) cap0.push_back(bus0.w_data);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [31:0] d);
    bus.frame_valid = 1'b1;
    bus.frame_data  = d;
    step();
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80 && !bus.frame_ready; i++) step();
    check_eq(tag, bus.frame_ready, 1'b1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] q[$], input int start,
                             input logic [47:0] exp);
    logic [47:0] got;
    got = '0;
    for (int i = 0; i < 6; i++) begin
      got = {got[39:0], (q.size() > start + i) ? q[start + i] : 8'h00};
    end
    check_eq(tag, got, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_valid  = 1'b0;
    bus.frame_data   = '0;
    bus.tx_full      = 1'b0;
    bus0.frame_valid = 1'b0;
    bus0.frame_data  = '0;
    bus0.tx_full     = 1'b0;
    model_reset();

    #3;
    check_eq("rst_frame_ready", bus.frame_ready, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_wr_uart", bus.wr_uart, 1'b0);
    check_eq("rst_w_data", bus.w_data, 8'h00);
    check_eq("rst_frames_sent", bus.frames_sent, 16'h0000);
    check_eq("rst_gap0_ready", bus0.frame_ready, 1'b1);
    #9;
    rst = 1'b1;

    // Basic frame and gap length.
    cap.delete();
    send(32'h12345678);
    run(6);
    check_bytes("basic_bytes", cap, 0, 48'hA5_12_34_56_78_08);
    check_eq("basic_count", cap.size(), 6);
    wait_idle("basic_idle");
    check_eq("basic_gap_len", cyc - last_strobe, 16);
    check_eq("basic_frames", bus.frames_sent, 16'd1);

    // Back-pressure after the second strobe.
    cap.delete();
    send(32'h12345678);
    run(2);
    bus.tx_full = 1'b1;
    run(3);
    check_eq("bp_stalled", cap.size(), 2);
    bus.tx_full = 1'b0;
    run(4);
    check_bytes("bp_bytes", cap, 0, 48'hA5_12_34_56_78_08);
    check_eq("bp_count", cap.size(), 6);
    wait_idle("bp_idle");

    // Offer during D1 is ignored.
    cap.delete();
    send(32'h12345678);
    run(2);
    bus.frame_valid = 1'b1;
    bus.frame_data  = 32'hFFFF_FFFF;
    step();
    bus.frame_valid = 1'b0;
    run(3);
    check_bytes("ignored_bytes", cap, 0, 48'hA5_12_34_56_78_08);
    wait_idle("ignored_idle");
    check_eq("ignored_frames", bus.frames_sent, 16'd3);
    check_eq("ignored_count", cap.size(), 6);

    // Asynchronous reset during D2.
    send(32'h12345678);
    run(3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_wr_uart", bus.wr_uart, 1'b0);
    check_eq("midrst_frames", bus.frames_sent, 16'h0000);
    check_eq("midrst_ready", bus.frame_ready, 1'b1);
    @(posedge pclk);
    #3;
    rst = 1'b1;
    cap.delete();
    send(32'h01000005);
    run(6);
    check_bytes("midrst_next_bytes", cap, 0, 48'hA5_01_00_00_05_04);
    wait_idle("midrst_idle");

    // Back-to-back with frame_valid held high.
    bus.frame_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      bus.frame_data = $urandom;
      step();
    end
    bus.frame_valid = 1'b0;
    wait_idle("b2b_idle");

    // Random traffic with random back-pressure.
    for (int i = 0; i < 1500; i++) begin
      bus.frame_valid = ($urandom_range(0, 2) == 0);
      bus.frame_data  = $urandom;
      bus.tx_full     = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.frame_valid = 1'b0;
    bus.tx_full     = 1'b0;
    wait_idle("rand_idle");

    // Zero-gap instance: CHK returns straight to IDLE.
    cap0.delete();
    bus0.frame_data  = 32'h12345678;
    bus0.frame_valid = 1'b1;
    step();
    run(6);
    check_eq("gap0_chk_strobe", bus0.wr_uart, 1'b1);
    check_eq("gap0_ready_after_chk", bus0.frame_ready, 1'b1);
    step();
    bus0.frame_valid = 1'b0;
    check_eq("gap0_reaccept", bus0.busy, 1'b1);
    run(6);
    check_eq("gap0_count", cap0.size(), 12);
    check_eq("gap0_frames", bus0.frames_sent, 16'd2);
    check_bytes("gap0_first", cap0, 0, 48'hA5_12_34_56_78_08);
    check_bytes("gap0_second", cap0, 6, 48'hA5_12_34_56_78_08);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16: the number of idle cycles required after each frame before the next is accepted.
REQ-003 The block SHALL have port pclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port frame_data, input, 32 bits: the word to send ({board_ID, 24-bit BCD points}).
REQ-006 The block SHALL have port frame_valid, input, 1 bit: the producer offers frame_data.
REQ-007 The block SHALL have port frame_ready, output, 1 bit: the block can accept a frame this cycle.
REQ-008 The block SHALL have port tx_full, input, 1 bit: the UART transmit FIFO is full; no write is allowed.
REQ-009 The block SHALL have port wr_uart, output, 1 bit: a one-cycle write strobe to the UART transmit FIFO.
REQ-010 The block SHALL have port w_data, output, 8 bits: the byte written when wr_uart=1.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port frames_sent, output, 16 bits: the count of completed frames.

Function
REQ-013 The FSM SHALL use states IDLE, SYNC, D0, D1, D2, D3, CHK, GAP.
REQ-014 frame_ready SHALL be 1 only in IDLE, and busy SHALL equal the inverse of frame_ready.
REQ-015 On a rising edge with IDLE and frame_valid=1, the block SHALL latch frame_data into an internal register and move to SYNC.
REQ-016 frame_valid while not IDLE SHALL be ignored; the latched word SHALL stay unchanged.
REQ-017 In SYNC through CHK, on an edge with tx_full=0, the block SHALL register wr_uart<=1 and w_data<=byte, then advance one state.
REQ-018 On an edge with tx_full=1, the block SHALL register wr_uart<=0, hold the state, and neither skip nor repeat any byte.
REQ-019 Bytes SHALL be sent in the order SYNC_BYTE, data[31:24], data[23:16], data[15:8], data[7:0], checksum.
REQ-020 The checksum SHALL be the 8-bit XOR of the four data bytes.
REQ-021 wr_uart SHALL be 0 in every cycle not produced by REQ-017; w_data SHALL hold its last value when wr_uart=0.
REQ-022 Exactly 6 wr_uart pulses SHALL occur per accepted frame.
REQ-023 Latency without back-pressure: accept on edge k, writes on edges k+1 through k+6.
REQ-024 On the CHK write, the state SHALL go to GAP and frames_sent SHALL increment by 1, wrapping 16'hFFFF to 16'h0000.
REQ-025 GAP SHALL last GAP_CYCLES cycles, then the state SHALL return to IDLE.
REQ-026 With GAP_CYCLES=0, CHK SHALL go directly to IDLE.
REQ-027 The GAP counter SHALL be wide enough for GAP_CYCLES with no overflow.
REQ-028 tx_full changing in GAP or IDLE SHALL have no effect.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for a clock edge, set: state IDLE, wr_uart 0, w_data 8'h00, frames_sent 0, latched word 0, GAP counter 0.
REQ-030 The reset values SHALL give frame_ready=1 and busy=0.
REQ-031 Reset mid-frame SHALL abort the frame with no further wr_uart pulses, and frames_sent SHALL NOT increment.
REQ-032 After rst returns to 1, the first edge SHALL behave as IDLE.

Verification
REQ-033 Basic frame: frame_data=32'h12345678 with valid for 1 cycle and tx_full=0 -> w_data on consecutive strobes A5,12,34,56,78,08; frames_sent=1; frame_ready back to 1 exactly 16 cycles after the last strobe.
REQ-034 Back-pressure: same frame, tx_full=1 for 3 cycles after the 2nd strobe -> strobes stop for 3 cycles, then resume at 34; 6 strobes total; no duplicates.
REQ-035 Ignored offer: a second frame_valid with 32'hFFFFFFFF during D1 -> output bytes unchanged from the basic frame; only one frame sent.
REQ-036 Reset mid-frame: rst=0 asserted during D2 -> wr_uart=0 immediately and frames_sent=0; the next frame 32'h01000005 after release -> A5,01,00,00,05,04.
REQ-037 Wrap: 65536 frames with GAP_CYCLES=0 -> frames_sent goes FFFF then 0000, with 393216 strobes total.
REQ-038 Back-to-back: frame_valid held high continuously -> a new frame is accepted on the first IDLE edge after GAP, with no strobe during GAP.
